// File: rtl/safe_pkg.sv
// Shared types for the keypad safe family: input tokens, output events,
// controller states and the stored-code record.
package safe_pkg;

    localparam int CODE_MAX_LENGTH = 8;
    localparam int CODE_LEN_W      = $clog2(CODE_MAX_LENGTH) + 1;

    typedef enum logic [3:0] {
        DIGIT_0     = 4'd0,
        DIGIT_1     = 4'd1,
        DIGIT_2     = 4'd2,
        DIGIT_3     = 4'd3,
        DIGIT_4     = 4'd4,
        DIGIT_5     = 4'd5,
        DIGIT_6     = 4'd6,
        DIGIT_7     = 4'd7,
        DIGIT_8     = 4'd8,
        DIGIT_9     = 4'd9,
        KEY_CLEAR   = 4'd10,
        KEY_OK      = 4'd11,
        DOOR_SEALED = 4'd12
    } data_in;

    typedef enum logic [2:0] {
        PASS_OK,
        PASS_FAIL,
        DOOR_LOCK,
        CODE_SET_MODE,
        BLOCK,
        TIMEOUT,
        LOCKOUT_END
    } data_out;

    typedef enum logic [2:0] {
        OPEN,
        LOCKED,
        CODE_CHECK,
        CODE_SET,
        CODE_CONFIRM,
        BLOCKED
    } safe_mu_state;

    // Unused digit positions are always zero, so whole-record equality is a valid code compare.
    typedef struct packed {
        logic [CODE_MAX_LENGTH-1:0][3:0] digits;
        logic [CODE_LEN_W-1:0]           length;
    } code_entry_t;

    function automatic logic is_digit(input data_in tok);
        return tok <= DIGIT_9;
    endfunction

endpackage

// File: rtl/safe_code_buffer.sv
// Digit entry buffer: appends digits up to the maximum length, clears on request,
// and compares the current entry against a reference code.
module safe_code_buffer
    import safe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [3:0]  digit_i,
    input  code_entry_t ref_i,
    output code_entry_t entry_o,
    output logic        match_o
);

    code_entry_t entry_q;
    code_entry_t entry_d;

    // Digits beyond the maximum length are silently dropped.
    always_comb begin
        entry_d = entry_q;
        if (clear_i) begin
            entry_d = '0;
        end else if (push_i && (entry_q.length < CODE_LEN_W'(CODE_MAX_LENGTH))) begin
            entry_d.digits[entry_q.length[CODE_LEN_W-2:0]] = digit_i;
            entry_d.length = entry_q.length + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;
    assign match_o = (ref_i.length != '0) && (ref_i == entry_q);

endmodule

// File: rtl/safe_multi_user.sv
// Multi-user keypad safe: per-user codes, escalating timed lockout, mechanical override,
// and one registered output event held under valid/ready backpressure.
module safe_multi_user
    import safe_pkg::*;
#(
    parameter int CODE_MIN_LENGTH         = 4,
    parameter int USER_COUNT              = 4,
    parameter int WRONG_ATTEMPTS_TO_BLOCK = 3,
    parameter int TIMEOUT_VALUE           = 1000,
    parameter int LONG_PRESS_VALUE        = 100,
    parameter int LOCKOUT_BASE            = 4096,
    parameter int LOCKOUT_MAX_SHIFT       = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  data_in                        data_in_i,
    input  logic [$clog2(USER_COUNT)-1:0] user_i,
    input  logic                          data_in_valid_i,
    output logic                          data_in_ready_o,
    input  logic                          unlock_i,
    input  logic                          unlock_valid_i,
    output logic                          unlock_ready_o,
    output data_out                       data_out_o,
    output logic [$clog2(USER_COUNT)-1:0] data_out_user_o,
    output logic                          data_out_valid_o,
    input  logic                          data_out_ready_i
);

    localparam int USER_W = $clog2(USER_COUNT);
    localparam int TO_W   = $clog2(TIMEOUT_VALUE) + 1;
    localparam int LP_W   = $clog2(LONG_PRESS_VALUE) + 1;
    localparam int LO_W   = $clog2(LOCKOUT_BASE << LOCKOUT_MAX_SHIFT) + 1;
    localparam int LVL_W  = $clog2(LOCKOUT_MAX_SHIFT + 1);
    localparam int WR_W   = $clog2(WRONG_ATTEMPTS_TO_BLOCK + 1);

    safe_mu_state      state_q;
    logic [USER_W-1:0] active_user_q;
    code_entry_t       slots_q [USER_COUNT];
    code_entry_t       pending_q;
    logic [WR_W-1:0]   wrong_q;
    logic [LVL_W-1:0]  level_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [LP_W-1:0]   lp_cnt_q;
    logic [LO_W-1:0]   lo_cnt_q;
    logic              out_valid_q;
    data_out           out_data_q;
    logic [USER_W-1:0] out_user_q;

    logic        in_fire, is_dig, set_state, entry_state, any_slot;
    logic        to_fire, lp_clear, lp_fire, lo_fire, unlock_fire;
    logic        buf_push, buf_clear, buf_match;
    logic [LO_W-1:0] lock_len;
    code_entry_t buf_entry, cmp_ref;

    assign data_in_ready_o  = ~rst_i & ~out_valid_q;
    assign unlock_ready_o   = ~rst_i & (state_q == BLOCKED) & ~out_valid_q;
    assign data_out_valid_o = out_valid_q;
    assign data_out_o       = out_data_q;
    assign data_out_user_o  = out_user_q;

    always_comb begin
        any_slot = 1'b0;
        for (int u = 0; u < USER_COUNT; u++) begin
            any_slot = any_slot | (slots_q[u].length != '0);
        end
    end

    // Timer events only fire while the output register is free; their counters saturate meanwhile.
    assign in_fire     = data_in_valid_i & data_in_ready_o;
    assign is_dig      = is_digit(data_in_i);
    assign set_state   = (state_q == CODE_SET) || (state_q == CODE_CONFIRM);
    assign entry_state = set_state || (state_q == CODE_CHECK);
    assign to_fire     = entry_state && !data_in_valid_i && !out_valid_q
                         && (to_cnt_q == TO_W'(TIMEOUT_VALUE));
    assign lp_clear    = (state_q == OPEN) && data_in_valid_i && (data_in_i == KEY_CLEAR);
    assign lp_fire     = lp_clear && !out_valid_q && (lp_cnt_q >= LP_W'(LONG_PRESS_VALUE - 1));
    assign lock_len    = LO_W'(LOCKOUT_BASE) << level_q;
    assign unlock_fire = unlock_valid_i & unlock_ready_o & unlock_i;
    assign lo_fire     = (state_q == BLOCKED) && !out_valid_q && !unlock_fire
                         && (lo_cnt_q >= lock_len - 1'b1);
    assign buf_push    = in_fire && is_dig && (state_q != OPEN) && (state_q != BLOCKED);
    assign buf_clear   = to_fire || (in_fire && ((data_in_i == KEY_CLEAR) || (data_in_i == KEY_OK)
                         || (set_state && (data_in_i == DOOR_SEALED))));
    assign cmp_ref     = (state_q == CODE_CONFIRM) ? pending_q : slots_q[active_user_q];

    safe_code_buffer u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (buf_clear),
        .push_i  (buf_push),
        .digit_i (data_in_i),
        .ref_i   (cmp_ref),
        .entry_o (buf_entry),
        .match_o (buf_match)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= OPEN;
            active_user_q <= '0;
            for (int u = 0; u < USER_COUNT; u++) begin
                slots_q[u] <= '0;
            end
            pending_q     <= '0;
            wrong_q       <= '0;
            level_q       <= '0;
            to_cnt_q      <= '0;
            lp_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= PASS_OK;
            out_user_q    <= '0;
        end else begin
            to_cnt_q <= (!entry_state || data_in_valid_i || to_fire) ? '0 :
                        (to_cnt_q == TO_W'(TIMEOUT_VALUE)) ? to_cnt_q : to_cnt_q + 1'b1;
            lp_cnt_q <= (!lp_clear || lp_fire) ? '0 :
                        (lp_cnt_q >= LP_W'(LONG_PRESS_VALUE - 1)) ? lp_cnt_q : lp_cnt_q + 1'b1;
            lo_cnt_q <= ((state_q != BLOCKED) || lo_fire || unlock_fire) ? '0 :
                        (lo_cnt_q >= lock_len - 1'b1) ? lo_cnt_q : lo_cnt_q + 1'b1;

            if (out_valid_q && data_out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            // The event user tracks the active user while free and freezes once an event is held.
            if (!out_valid_q) begin
                out_user_q <= lp_fire ? user_i : active_user_q;
            end

            if (unlock_fire) begin
                level_q     <= '0;
                wrong_q     <= '0;
                state_q     <= OPEN;
                out_valid_q <= 1'b1;
                out_data_q  <= PASS_OK;
            end else if (lo_fire) begin
                if (level_q < LVL_W'(LOCKOUT_MAX_SHIFT)) begin
                    level_q <= level_q + 1'b1;
                end
                wrong_q     <= '0;
                state_q     <= LOCKED;
                out_valid_q <= 1'b1;
                out_data_q  <= LOCKOUT_END;
            end else if (to_fire) begin
                state_q     <= (state_q == CODE_CHECK) ? LOCKED : OPEN;
                out_valid_q <= 1'b1;
                out_data_q  <= TIMEOUT;
            end else if (lp_fire) begin
                active_user_q <= user_i;
                state_q       <= CODE_SET;
                out_valid_q   <= 1'b1;
                out_data_q    <= CODE_SET_MODE;
            end else if (in_fire) begin
                case (state_q)
                    LOCKED: begin
                        if (is_dig) begin
                            active_user_q <= user_i;
                            state_q       <= CODE_CHECK;
                        end
                    end
                    CODE_CHECK: begin
                        if (data_in_i == KEY_OK) begin
                            out_valid_q <= 1'b1;
                            if (buf_match) begin
                                wrong_q    <= '0;
                                level_q    <= '0;
                                state_q    <= OPEN;
                                out_data_q <= PASS_OK;
                            end else begin
                                wrong_q <= wrong_q + 1'b1;
                                if ((wrong_q + 1'b1) >= WR_W'(WRONG_ATTEMPTS_TO_BLOCK)) begin
                                    state_q    <= BLOCKED;
                                    out_data_q <= BLOCK;
                                end else begin
                                    state_q    <= LOCKED;
                                    out_data_q <= PASS_FAIL;
                                end
                            end
                        end
                    end
                    CODE_SET, CODE_CONFIRM: begin
                        if (data_in_i == KEY_OK) begin
                            if (state_q == CODE_SET) begin
                                if (buf_entry.length >= CODE_LEN_W'(CODE_MIN_LENGTH)) begin
                                    pending_q <= buf_entry;
                                    state_q   <= CODE_CONFIRM;
                                end else begin
                                    out_valid_q <= 1'b1;
                                    out_data_q  <= PASS_FAIL;
                                end
                            end else if (buf_match) begin
                                slots_q[active_user_q] <= pending_q;
                                state_q     <= OPEN;
                                out_valid_q <= 1'b1;
                                out_data_q  <= PASS_OK;
                            end else begin
                                state_q     <= CODE_SET;
                                out_valid_q <= 1'b1;
                                out_data_q  <= PASS_FAIL;
                            end
                        end else if (data_in_i == DOOR_SEALED) begin
                            state_q <= any_slot ? LOCKED : OPEN;
                            if (any_slot) begin
                                out_valid_q <= 1'b1;
                                out_data_q  <= DOOR_LOCK;
                            end
                        end
                    end
                    OPEN: begin
                        if ((data_in_i == DOOR_SEALED) && any_slot) begin
                            state_q     <= LOCKED;
                            out_valid_q <= 1'b1;
                            out_data_q  <= DOOR_LOCK;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_safe_multi_user.sv
// Directed self-checking bench for safe_multi_user: code set/confirm, per-user checks,
// escalating lockout, override, timeout and output backpressure.
module tb_safe_multi_user;
    import safe_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    data_in     data_in_i;
    logic [1:0] user_i;
    logic       data_in_valid_i;
    logic       data_in_ready_o;
    logic       unlock_i;
    logic       unlock_valid_i;
    logic       unlock_ready_o;
    data_out    data_out_o;
    logic [1:0] data_out_user_o;
    logic       data_out_valid_o;
    logic       data_out_ready_i;

    int checks = 0;
    int errors = 0;
    int waited;
    logic stable;

    always #5 clk_i = ~clk_i;

    safe_multi_user dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .data_in_i        (data_in_i),
        .user_i           (user_i),
        .data_in_valid_i  (data_in_valid_i),
        .data_in_ready_o  (data_in_ready_o),
        .unlock_i         (unlock_i),
        .unlock_valid_i   (unlock_valid_i),
        .unlock_ready_o   (unlock_ready_o),
        .data_out_o       (data_out_o),
        .data_out_user_o  (data_out_user_o),
        .data_out_valid_o (data_out_valid_o),
        .data_out_ready_i (data_out_ready_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic applyStimulus(input data_in tok, input logic [1:0] usr);
        int n;
        n = 0;
        while (!data_in_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        checkOutput("in_ready", data_in_ready_o, 1);
        data_in_i       = tok;
        user_i          = usr;
        data_in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        data_in_valid_i = 1'b0;
    endtask

    task automatic enterCode(input logic [31:0] code, input int len, input logic [1:0] usr);
        for (int i = len - 1; i >= 0; i--) begin
            applyStimulus(data_in'(code[4*i +: 4]), usr);
        end
        applyStimulus(KEY_OK, usr);
    endtask

    task automatic expectEventW(input string tag, input data_out exp, input logic [1:0] expUser,
                                input int maxCycles, output int cyc);
        int n;
        n = 0;
        while (!data_out_valid_o && n < maxCycles) begin
            @(posedge clk_i); #1;
            n++;
        end
        cyc = n;
        checkOutput({tag, "_valid"}, data_out_valid_o, 1);
        checkOutput({tag, "_event"}, data_out_o, exp);
        checkOutput({tag, "_user"}, data_out_user_o, expUser);
        data_out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        data_out_ready_i = 1'b0;
    endtask

    task automatic expectEvent(input string tag, input data_out exp, input logic [1:0] expUser);
        int cyc;
        expectEventW(tag, exp, expUser, 20, cyc);
    endtask

    task automatic expectQuiet(input string tag, input int cycles);
        repeat (cycles) begin
            @(posedge clk_i); #1;
        end
        checkOutput(tag, data_out_valid_o, 0);
    endtask

    task automatic longPress(input logic [1:0] usr, output int cyc);
        int n;
        n = 0;
        data_in_i       = KEY_CLEAR;
        user_i          = usr;
        data_in_valid_i = 1'b1;
        while (!data_out_valid_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        data_in_valid_i = 1'b0;
        cyc = n;
    endtask

    task automatic overrideUnlock(input logic val);
        int n;
        n = 0;
        while (!unlock_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        checkOutput("unlock_ready", unlock_ready_o, 1);
        unlock_i       = val;
        unlock_valid_i = 1'b1;
        @(posedge clk_i); #1;
        unlock_valid_i = 1'b0;
        unlock_i       = 1'b0;
    endtask

    task automatic threeWrong(input string tag);
        enterCode(32'h5555, 4, 2'd1);
        expectEvent({tag, "_w1"}, PASS_FAIL, 2'd1);
        enterCode(32'h5555, 4, 2'd1);
        expectEvent({tag, "_w2"}, PASS_FAIL, 2'd1);
        enterCode(32'h5555, 4, 2'd1);
        expectEvent({tag, "_w3"}, BLOCK, 2'd1);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_i            = 1'b1;
        data_in_i        = DIGIT_0;
        user_i           = 2'd0;
        data_in_valid_i  = 1'b0;
        unlock_i         = 1'b0;
        unlock_valid_i   = 1'b0;
        data_out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_in_ready", data_in_ready_o, 0);
        checkOutput("rst_out_valid", data_out_valid_o, 0);
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", data_in_ready_o, 1);
        checkOutput("post_rst_unlock_ready", unlock_ready_o, 0);

        // Sealing with no codes stored does nothing.
        applyStimulus(DOOR_SEALED, 2'd0);
        expectQuiet("seal_empty_quiet", 5);

        // Set user 2's code 1234 and use it.
        longPress(2'd2, waited);
        checkOutput("longpress_cycles", waited, 100);
        expectEvent("setmode", CODE_SET_MODE, 2'd2);
        enterCode(32'h1234, 4, 2'd2);
        expectQuiet("set_first_quiet", 5);
        enterCode(32'h1234, 4, 2'd2);
        expectEvent("confirm_ok", PASS_OK, 2'd2);
        applyStimulus(DOOR_SEALED, 2'd0);
        expectEvent("seal1", DOOR_LOCK, 2'd2);
        enterCode(32'h1234, 4, 2'd2);
        expectEvent("open_u2", PASS_OK, 2'd2);
        applyStimulus(DOOR_SEALED, 2'd0);
        expectEvent("seal2", DOOR_LOCK, 2'd2);

        // Short entry, then right code for an empty slot, then a third wrong submit blocks.
        enterCode(32'h123, 3, 2'd1);
        expectEvent("short", PASS_FAIL, 2'd1);
        enterCode(32'h1234, 4, 2'd1);
        expectEvent("empty_slot", PASS_FAIL, 2'd1);
        enterCode(32'h9999, 4, 2'd1);
        checkOutput("blocked_unlock_ready_held", unlock_ready_o, 0);
        checkOutput("blocked_in_ready_held", data_in_ready_o, 0);
        expectEvent("block1", BLOCK, 2'd1);
        checkOutput("blocked_unlock_ready", unlock_ready_o, 1);
        expectEventW("lockend1", LOCKOUT_END, 2'd1, 9000, waited);
        checkRange("lockout1_cycles", waited, 4090, 4100);

        // Second lockout is doubled.
        threeWrong("blk2");
        expectEventW("lockend2", LOCKOUT_END, 2'd1, 9000, waited);
        checkRange("lockout2_cycles", waited, 8186, 8196);

        // Override from the third block resets the level.
        threeWrong("blk3");
        overrideUnlock(1'b0);
        expectQuiet("unlock0_quiet", 3);
        checkOutput("unlock0_still_blocked", unlock_ready_o, 1);
        overrideUnlock(1'b1);
        expectEvent("override", PASS_OK, 2'd1);
        checkOutput("override_unlock_ready", unlock_ready_o, 0);
        applyStimulus(DOOR_SEALED, 2'd0);
        expectEvent("seal3", DOOR_LOCK, 2'd1);
        threeWrong("blk4");
        expectEventW("lockend4", LOCKOUT_END, 2'd1, 9000, waited);
        checkRange("lockout4_cycles", waited, 4090, 4100);

        // Confirm mismatch, then timeout leaves the old code in place.
        enterCode(32'h1234, 4, 2'd2);
        expectEvent("open_u2_b", PASS_OK, 2'd2);
        longPress(2'd2, waited);
        expectEvent("setmode2", CODE_SET_MODE, 2'd2);
        enterCode(32'h5678, 4, 2'd2);
        expectQuiet("set2_quiet", 3);
        enterCode(32'h5679, 4, 2'd2);
        expectEvent("confirm_bad", PASS_FAIL, 2'd2);
        expectEventW("timeout1", TIMEOUT, 2'd2, 1200, waited);
        checkRange("timeout1_cycles", waited, 995, 1005);
        applyStimulus(DOOR_SEALED, 2'd0);
        expectEvent("seal4", DOOR_LOCK, 2'd2);
        enterCode(32'h1234, 4, 2'd2);
        expectEvent("old_code", PASS_OK, 2'd2);

        // Hold an event across a timeout: it stays stable and the timeout follows it.
        longPress(2'd2, waited);
        expectEvent("setmode3", CODE_SET_MODE, 2'd2);
        enterCode(32'h12, 2, 2'd2);
        stable = 1'b1;
        repeat (1100) begin
            @(posedge clk_i); #1;
            if (!data_out_valid_o || data_out_o != PASS_FAIL || data_in_ready_o) stable = 1'b0;
        end
        checkOutput("held_stable", stable, 1);
        expectEvent("held_fail", PASS_FAIL, 2'd2);
        expectEventW("held_timeout", TIMEOUT, 2'd2, 10, waited);
        checkRange("held_timeout_cycles", waited, 0, 2);
        applyStimulus(DOOR_SEALED, 2'd0);
        expectEvent("seal5", DOOR_LOCK, 2'd2);

        // Reset in the middle of a pending event loses everything.
        enterCode(32'h1234, 4, 2'd2);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("midrst_valid", data_out_valid_o, 0);
        checkOutput("midrst_data", data_out_o, 0);
        checkOutput("midrst_user", data_out_user_o, 0);
        checkOutput("midrst_in_ready", data_in_ready_o, 0);
        rst_i = 1'b0;
        #1;
        applyStimulus(DOOR_SEALED, 2'd0);
        expectQuiet("midrst_codes_lost", 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
